alu_multicycle: RTL and testbench

Parametrised successor to the 32-bit single-cycle ALU.
- Generalises datapath width.
- Registers all outputs and adds a valid/ready handshake.
- Adds multi-cycle unsigned multiply and divide with a 2×WIDTH result (hi/lo).
- Sits between register-file read and writeback in the MIPS datapath. Control stalls issue while in_ready is low.

---
 rtl/alu_multicycle.sv | 165 ++++++++++++++++
 tb/tb_alu_multicycle.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/alu_multicycle.sv
// Multi-cycle ALU: registered single-cycle logic ops plus iterative unsigned
// multiply (shift-add) and divide (restoring), behind a valid/ready handshake.
module alu_multicycle #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [3:0]       operation,
    input  logic [WIDTH-1:0] data_0,
    input  logic [WIDTH-1:0] data_1,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             overflow,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_NOR   = 4'b1100;
    localparam logic [3:0] OP_MULTU = 4'b1000;
    localparam logic [3:0] OP_DIVU  = 4'b1001;

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] hi_q, lo_q, opnd_q;
    logic             dz_q;

    logic             out_valid_q, zero_q, overflow_q, div_by_zero_q;
    logic [WIDTH-1:0] result_q, result_hi_q;

    logic [WIDTH-1:0] add_res, sub_res, sc_result;
    logic             sc_ovf;
    logic [WIDTH:0]   mul_sum, div_shift, div_trial;
    logic [WIDTH-1:0] hi_d, lo_d;

    assign add_res = data_0 + data_1;
    assign sub_res = data_0 - data_1;

    always_comb begin
        sc_result = '0;
        sc_ovf    = 1'b0;
        case (operation)
            OP_AND: sc_result = data_0 & data_1;
            OP_OR:  sc_result = data_0 | data_1;
            OP_ADD: begin
                sc_result = add_res;
                sc_ovf    = (data_0[WIDTH-1] == data_1[WIDTH-1]) &&
                            (add_res[WIDTH-1] != data_0[WIDTH-1]);
            end
            OP_SUB: begin
                sc_result = sub_res;
                sc_ovf    = (data_0[WIDTH-1] != data_1[WIDTH-1]) &&
                            (sub_res[WIDTH-1] != data_0[WIDTH-1]);
            end
            OP_SLT: sc_result = {{(WIDTH-1){1'b0}}, ($signed(data_0) < $signed(data_1))};
            OP_NOR: sc_result = ~(data_0 | data_1);
            default: sc_result = '0;
        endcase
    end

    // MUL: {hi,lo} holds partial product and the unconsumed multiplier bits.
    // DIV: hi is the partial remainder, lo shifts dividend out and quotient in.
    // A zero divisor falls out naturally as quotient all-ones, remainder = dividend.
    assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    assign div_shift = {hi_q, lo_q[WIDTH-1]};
    assign div_trial = div_shift - {1'b0, opnd_q};

    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (state_q == MUL) begin
            hi_d = mul_sum[WIDTH:1];
            lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
        end else if (state_q == DIV) begin
            if (!div_trial[WIDTH]) begin
                hi_d = div_trial[WIDTH-1:0];
                lo_d = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                hi_d = div_shift[WIDTH-1:0];
                lo_d = {lo_q[WIDTH-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            hi_q          <= '0;
            lo_q          <= '0;
            opnd_q        <= '0;
            dz_q          <= 1'b0;
            out_valid_q   <= 1'b0;
            result_q      <= '0;
            result_hi_q   <= '0;
            zero_q        <= 1'b0;
            overflow_q    <= 1'b0;
            div_by_zero_q <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        if (operation == OP_MULTU) begin
                            state_q <= MUL;
                            cnt_q   <= '0;
                            hi_q    <= '0;
                            lo_q    <= data_1;
                            opnd_q  <= data_0;
                            dz_q    <= 1'b0;
                        end else if (operation == OP_DIVU) begin
                            state_q <= DIV;
                            cnt_q   <= '0;
                            hi_q    <= '0;
                            lo_q    <= data_0;
                            opnd_q  <= data_1;
                            dz_q    <= (data_1 == '0);
                        end else begin
                            out_valid_q   <= 1'b1;
                            result_q      <= sc_result;
                            result_hi_q   <= '0;
                            zero_q        <= (sc_result == '0);
                            overflow_q    <= sc_ovf;
                            div_by_zero_q <= 1'b0;
                        end
                    end
                end
                MUL, DIV: begin
                    hi_q  <= hi_d;
                    lo_q  <= lo_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_q       <= IDLE;
                        cnt_q         <= '0;
                        out_valid_q   <= 1'b1;
                        result_q      <= lo_d;
                        result_hi_q   <= hi_d;
                        zero_q        <= (lo_d == '0);
                        overflow_q    <= 1'b0;
                        div_by_zero_q <= dz_q;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = out_valid_q;
    assign result      = result_q;
    assign result_hi   = result_hi_q;
    assign zero        = zero_q;
    assign overflow    = overflow_q;
    assign div_by_zero = div_by_zero_q;
endmodule

// File: tb/tb_alu_multicycle.sv
// Directed bench for alu_multicycle: a 32-bit and an 8-bit instance share the
// input bus; sel routes in_valid and picks which outputs are observed.
module tb_alu_multicycle;
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  op = '0;
    logic [31:0] da = '0, db = '0;
    logic        in_valid = 1'b0;
    logic        sel = 1'b0;

    logic        rdy32, ov32_v, z32, of32, dz32;
    logic [31:0] r32, rh32;
    logic        rdy8, ov8_v, z8, of8, dz8;
    logic [7:0]  r8, rh8;

    logic        o_ready, o_valid, o_zero, o_ovf, o_dz;
    logic [31:0] o_res, o_hi;

    int n_vec = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    alu_multicycle #(.WIDTH(32)) dut32 (
        .clock(clock), .reset_n(reset_n), .operation(op),
        .data_0(da), .data_1(db), .in_valid(in_valid && !sel),
        .in_ready(rdy32), .out_valid(ov32_v), .result(r32), .result_hi(rh32),
        .zero(z32), .overflow(of32), .div_by_zero(dz32)
    );

    alu_multicycle #(.WIDTH(8)) dut8 (
        .clock(clock), .reset_n(reset_n), .operation(op),
        .data_0(da[7:0]), .data_1(db[7:0]), .in_valid(in_valid && sel),
        .in_ready(rdy8), .out_valid(ov8_v), .result(r8), .result_hi(rh8),
        .zero(z8), .overflow(of8), .div_by_zero(dz8)
    );

    assign o_ready = sel ? rdy8  : rdy32;
    assign o_valid = sel ? ov8_v : ov32_v;
    assign o_res   = sel ? {24'h0, r8}  : r32;
    assign o_hi    = sel ? {24'h0, rh8} : rh32;
    assign o_zero  = sel ? z8  : z32;
    assign o_ovf   = sel ? of8 : of32;
    assign o_dz    = sel ? dz8 : dz32;

    task automatic set_in(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        op = o; da = a; db = b; in_valid = 1'b1;
    endtask

    task automatic test_reset();
        sel = 1'b0;
        set_in(4'b0010, 32'd1, 32'd1);
        repeat (2) @(negedge clock);
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            n_vec++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL reset out_valid w%0d: got %b expected 0", sel ? 8 : 32, o_valid); end
            n_vec++; if (o_res !== 32'h0) begin n_err++; $display("FAIL reset result w%0d: got %h expected 0", sel ? 8 : 32, o_res); end
            n_vec++; if (o_hi !== 32'h0) begin n_err++; $display("FAIL reset result_hi w%0d: got %h expected 0", sel ? 8 : 32, o_hi); end
            n_vec++; if ({o_zero, o_ovf, o_dz} !== 3'b000) begin n_err++; $display("FAIL reset flags w%0d: got %b expected 000", sel ? 8 : 32, {o_zero, o_ovf, o_dz}); end
            n_vec++; if (o_ready !== 1'b1) begin n_err++; $display("FAIL reset in_ready w%0d: got %b expected 1", sel ? 8 : 32, o_ready); end
        end
        sel = 1'b0;
        @(negedge clock);
        reset_n  = 1'b1;
        in_valid = 1'b0;
        @(negedge clock);
        n_vec++; if (o_valid !== 1'b0 || o_res !== 32'h0) begin n_err++; $display("FAIL reset accept: out_valid=%b result=%h expected 0/0", o_valid, o_res); end
        $display("txn reset done");
    endtask

    task automatic test_back_to_back(input logic s);
        @(negedge clock);
        sel = s;
        set_in(4'b0010, 32'd1, 32'd3);
        @(negedge clock);
        n_vec++; if (o_valid !== 1'b1 || o_res !== 32'd4 || o_zero !== 1'b0) begin n_err++; $display("FAIL b2b ADD w%0d: valid=%b result=%h zero=%b expected 1/4/0", s ? 8 : 32, o_valid, o_res, o_zero); end
        n_vec++; if (o_ready !== 1'b1) begin n_err++; $display("FAIL b2b in_ready w%0d: got %b expected 1", s ? 8 : 32, o_ready); end
        set_in(4'b0110, 32'd3, 32'd1);
        @(negedge clock);
        n_vec++; if (o_valid !== 1'b1 || o_res !== 32'd2 || o_zero !== 1'b0) begin n_err++; $display("FAIL b2b SUB w%0d: valid=%b result=%h zero=%b expected 1/2/0", s ? 8 : 32, o_valid, o_res, o_zero); end
        n_vec++; if (o_ready !== 1'b1) begin n_err++; $display("FAIL b2b in_ready2 w%0d: got %b expected 1", s ? 8 : 32, o_ready); end
        in_valid = 1'b0;
        @(negedge clock);
        n_vec++; if (o_valid !== 1'b0 || o_res !== 32'd2) begin n_err++; $display("FAIL b2b hold w%0d: valid=%b result=%h expected 0/2", s ? 8 : 32, o_valid, o_res); end
        $display("txn b2b w%0d ADD 1,3 then SUB 3,1", s ? 8 : 32);
    endtask

    task automatic test_single_corners();
        localparam int N = 11;
        logic [3:0]  ops [N] = '{4'b0000, 4'b0001, 4'b0111, 4'b0111, 4'b0111, 4'b1100,
                                 4'b0101, 4'b0110, 4'b0010, 4'b0110, 4'b0010};
        logic [31:0] as  [N] = '{32'h0000F0F0, 32'h0000F0F0, 32'd10, 32'hFFFFFFFF, 32'd30, 32'd0,
                                 32'd3, 32'd5, 32'h7FFFFFFF, 32'h80000000, 32'd2};
        logic [31:0] bs  [N] = '{32'h0000FF00, 32'h0000FF00, 32'd30, 32'd1, 32'd10, 32'd0,
                                 32'd4, 32'd5, 32'd1, 32'd1, 32'd3};
        logic [31:0] er  [N] = '{32'h0000F000, 32'h0000FFF0, 32'd1, 32'd1, 32'd0, 32'hFFFFFFFF,
                                 32'd0, 32'd0, 32'h80000000, 32'h7FFFFFFF, 32'd5};
        logic        eo  [N] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        @(negedge clock);
        sel = 1'b0;
        set_in(ops[0], as[0], bs[0]);
        for (int i = 0; i < N; i++) begin
            @(negedge clock);
            n_vec++; if (o_valid !== 1'b1 || o_res !== er[i]) begin n_err++; $display("FAIL corner%0d result: valid=%b result=%h expected 1/%h", i, o_valid, o_res, er[i]); end
            n_vec++; if (o_zero !== (er[i] == 32'h0) || o_ovf !== eo[i]) begin n_err++; $display("FAIL corner%0d flags: zero=%b ovf=%b expected %b/%b", i, o_zero, o_ovf, er[i] == 32'h0, eo[i]); end
            n_vec++; if (o_hi !== 32'h0 || o_dz !== 1'b0) begin n_err++; $display("FAIL corner%0d hi/dz: hi=%h dz=%b expected 0/0", i, o_hi, o_dz); end
            $display("txn corner%0d op=%b a=%h b=%h result=%h", i, ops[i], as[i], bs[i], o_res);
            if (i + 1 < N) set_in(ops[i+1], as[i+1], bs[i+1]);
            else in_valid = 1'b0;
        end
    endtask

    task automatic test_mul_div(input logic s, input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] exp_lo, input logic [31:0] exp_hi, input logic exp_dz,
                                input string name);
        int w;
        int lat;
        int lows;
        w = s ? 8 : 32;
        @(negedge clock);
        sel = s;
        set_in(o, a, b);
        @(negedge clock);
        set_in(4'b0010, 32'd5, 32'd6);
        lat  = 0;
        lows = (o_ready === 1'b0) ? 1 : 0;
        while (lat < 200 && o_valid !== 1'b1) begin
            @(negedge clock);
            lat++;
            if (o_ready === 1'b0) lows++;
        end
        n_vec++; if (lat != w) begin n_err++; $display("FAIL %s latency w%0d: got %0d expected %0d", name, w, lat, w); end
        n_vec++; if (lows != w) begin n_err++; $display("FAIL %s in_ready low w%0d: got %0d cycles expected %0d", name, w, lows, w); end
        n_vec++; if (o_res !== exp_lo) begin n_err++; $display("FAIL %s result w%0d: got %h expected %h", name, w, o_res, exp_lo); end
        n_vec++; if (o_hi !== exp_hi) begin n_err++; $display("FAIL %s result_hi w%0d: got %h expected %h", name, w, o_hi, exp_hi); end
        n_vec++; if (o_dz !== exp_dz || o_ovf !== 1'b0 || o_zero !== (exp_lo == 32'h0)) begin n_err++; $display("FAIL %s flags w%0d: dz=%b ovf=%b zero=%b expected %b/0/%b", name, w, o_dz, o_ovf, o_zero, exp_dz, exp_lo == 32'h0); end
        n_vec++; if (o_ready !== 1'b1) begin n_err++; $display("FAIL %s in_ready at done w%0d: got %b expected 1", name, w, o_ready); end
        $display("txn %s w%0d a=%h b=%h lo=%h hi=%h latency=%0d", name, w, a, b, o_res, o_hi, lat);
        @(negedge clock);
        n_vec++; if (o_valid !== 1'b1 || o_res !== 32'd11 || o_hi !== 32'h0 || o_dz !== 1'b0) begin n_err++; $display("FAIL %s held ADD w%0d: valid=%b result=%h hi=%h dz=%b expected 1/b/0/0", name, w, o_valid, o_res, o_hi, o_dz); end
        in_valid = 1'b0;
        @(negedge clock);
        n_vec++; if (o_valid !== 1'b0 || o_res !== 32'd11) begin n_err++; $display("FAIL %s pulse/hold w%0d: valid=%b result=%h expected 0/b", name, w, o_valid, o_res); end
        $display("txn %s w%0d held ADD 5,6 -> %h", name, w, o_res);
    endtask

    task automatic test_reset_mid_op();
        int seen;
        @(negedge clock);
        sel = 1'b0;
        set_in(4'b1000, 32'd3, 32'd4);
        @(negedge clock);
        in_valid = 1'b0;
        repeat (9) @(negedge clock);
        reset_n = 1'b0;
        #1;
        n_vec++; if (o_valid !== 1'b0 || o_res !== 32'h0 || o_hi !== 32'h0) begin n_err++; $display("FAIL midreset outputs: valid=%b result=%h hi=%h expected 0/0/0", o_valid, o_res, o_hi); end
        n_vec++; if ({o_zero, o_ovf, o_dz} !== 3'b000 || o_ready !== 1'b1) begin n_err++; $display("FAIL midreset flags: zod=%b ready=%b expected 000/1", {o_zero, o_ovf, o_dz}, o_ready); end
        @(negedge clock);
        reset_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (o_valid === 1'b1) seen++;
        end
        n_vec++; if (seen != 0) begin n_err++; $display("FAIL midreset stray out_valid: got %0d pulses expected 0", seen); end
        set_in(4'b0010, 32'd2, 32'd2);
        @(negedge clock);
        n_vec++; if (o_valid !== 1'b1 || o_res !== 32'd4) begin n_err++; $display("FAIL midreset ADD: valid=%b result=%h expected 1/4", o_valid, o_res); end
        in_valid = 1'b0;
        $display("txn midreset MULTU aborted, ADD 2,2 -> %h", o_res);
    endtask

    initial begin
        test_reset();
        test_back_to_back(1'b0);
        test_mul_div(1'b0, 4'b1000, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE, 32'd1, 1'b0, "MULTU");
        test_single_corners();
        test_mul_div(1'b0, 4'b1001, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, "DIVU");
        test_mul_div(1'b0, 4'b1001, 32'd5, 32'd0, 32'hFFFFFFFF, 32'd5, 1'b1, "DIVU0");
        test_reset_mid_op();
        test_back_to_back(1'b1);
        test_mul_div(1'b1, 4'b1000, 32'h000000FF, 32'd2, 32'h000000FE, 32'd1, 1'b0, "MULTU");
        test_mul_div(1'b1, 4'b1001, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, "DIVU");
        test_mul_div(1'b1, 4'b1001, 32'd5, 32'd0, 32'h000000FF, 32'd5, 1'b1, "DIVU0");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
